// File: rtl/md5_pipeline.sv
// md5_pipeline: single-block MD5 over a 1..16 byte guess.
// 64 registered rounds, one digest per clock, 66-edge latency.
module md5_pipeline (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] guess,
  input  logic [3:0]   guesslen,
  output logic [31:0]  hashA,
  output logic [31:0]  hashB,
  output logic [31:0]  hashC,
  output logic [31:0]  hashD
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [2047:0] KT = {
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [79:0] RS = {
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic int msg_idx(input int s);
    case (s / 16)
      0:       return s;
      1:       return (5 * s + 1) % 16;
      2:       return (3 * s + 5) % 16;
      default: return (7 * s) % 16;
    endcase
  endfunction

  logic [4:0]   len;
  logic [511:0] pad;
  logic [64:0]  sv;
  logic [31:0]  sa [65];
  logic [31:0]  sb [65];
  logic [31:0]  sc [65];
  logic [31:0]  sd [65];
  logic [511:0] sm [64];
  logic [31:0]  nb [64];

  assign len = {1'b0, guesslen} + 5'd1;

  // Build the padded block; byte k sits at pad[8k +: 8] so words are little-endian.
  always_comb begin
    pad = '0;
    for (int k = 0; k < 16; k++) begin
      if (5'(k) < len) pad[8*k +: 8] = guess[127-8*k -: 8];
      else if (5'(k) == len) pad[8*k +: 8] = 8'h80;
    end
    if (len == 5'd16) pad[135:128] = 8'h80;
    pad[455:448] = {len, 3'b000};
  end

  for (genvar s = 0; s < 64; s++) begin : g_step
    localparam int R = s / 16;
    localparam int G = msg_idx(s);
    localparam int SH = int'(RS[(15 - (R * 4 + s % 4)) * 5 +: 5]);
    localparam logic [31:0] T = KT[(63 - s) * 32 +: 32];
    logic [31:0] fv;
    logic [31:0] sum;
    assign fv = (R == 0) ? ((sb[s] & sc[s]) | (~sb[s] & sd[s])) :
                (R == 1) ? ((sb[s] & sd[s]) | (sc[s] & ~sd[s])) :
                (R == 2) ? (sb[s] ^ sc[s] ^ sd[s]) :
                           (sc[s] ^ (sb[s] | ~sd[s]));
    assign sum = sa[s] + fv + T + sm[s][32*G +: 32];
    assign nb[s] = sb[s] + ((sum << SH) | (sum >> (32 - SH)));
  end

  // Valid bits shift one stage per edge; every non-reset edge injects a job.
  always_ff @(posedge clk) begin
    if (reset) sv <= '0;
    else       sv <= {sv[63:0], 1'b1};
  end

  // Round data registers; not reset, qualified by the valid chain.
  always_ff @(posedge clk) begin
    sa[0] <= IV_A;
    sb[0] <= IV_B;
    sc[0] <= IV_C;
    sd[0] <= IV_D;
    sm[0] <= pad;
    for (int s = 0; s < 64; s++) begin
      sa[s+1] <= sd[s];
      sb[s+1] <= nb[s];
      sc[s+1] <= sb[s];
      sd[s+1] <= sc[s];
    end
    for (int s = 0; s < 63; s++) sm[s+1] <= sm[s];
  end

  // Output register adds the IV back in and holds when no job arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      hashA <= '0;
      hashB <= '0;
      hashC <= '0;
      hashD <= '0;
    end else if (sv[64]) begin
      hashA <= IV_A + sa[64];
      hashB <= IV_B + sb[64];
      hashC <= IV_C + sc[64];
      hashD <= IV_D + sd[64];
    end
  end

endmodule

// File: tb/tb_md5_pipeline.sv
// tb_md5_pipeline: directed + random checks of md5_pipeline.
// Scoreboard entries carry the edge at which each digest is due.
module tb_md5_pipeline;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] guess;
  logic [3:0]   guesslen;
  logic [31:0]  hashA, hashB, hashC, hashD;

  md5_pipeline dut (
    .clk(clk), .reset(reset), .guess(guess), .guesslen(guesslen),
    .hashA(hashA), .hashB(hashB), .hashC(hashC), .hashD(hashD)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int S [16] = '{7, 12, 17, 22, 5, 9, 14, 20,
                            4, 11, 16, 23, 6, 10, 15, 21};

  localparam logic [127:0] G_A    = {8'h61, 120'h0};
  localparam logic [127:0] G_ABCD = {32'h61626364, 96'h0};
  localparam logic [127:0] G_16   = 128'h30313233343536373839616263646566;
  localparam logic [127:0] E_A    = 128'hb975c10c_a8b6f1c0_e299c331_61267769;
  localparam logic [127:0] E_ABC  = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
  localparam logic [127:0] E_ABCD = 128'h4c71fce2_93ee2747_cd24f395_1f337f2e;

  typedef struct {
    int           due;
    string        tag;
    logic [127:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  passed = 0;
  int  total = 0;
  int  due;

  function automatic logic [127:0] md5_ref(input logic [127:0] g, input int n);
    logic [7:0]  blk [64];
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t, x;
    int gi, sh;
    for (int k = 0; k < 64; k++) blk[k] = 8'h00;
    for (int k = 0; k < n; k++) blk[k] = g[127-8*k -: 8];
    blk[n] = 8'h80;
    blk[56] = 8'(n * 8);
    for (int i = 0; i < 16; i++)
      m[i] = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
    a = 32'h67452301; b = 32'hefcdab89;
    c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); gi = i; end
        1: begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d; gi = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); gi = (7 * i) % 16; end
      endcase
      sh = S[(i / 16) * 4 + i % 4];
      x = a + f + K[i] + m[gi];
      t = d; d = c; c = b;
      b = b + ((x << sh) | (x >> (32 - sh)));
      a = t;
    end
    return {a + 32'h67452301, b + 32'hefcdab89,
            c + 32'h98badcfe, d + 32'h10325476};
  endfunction

  function automatic logic [127:0] hash_now();
    return {hashA, hashB, hashC, hashD};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check(e.tag, hash_now(), e.exp);
    end
  endtask

  task automatic drive(input logic [127:0] g, input logic [3:0] n,
                       input string tag, input logic [127:0] exp);
    sb_t e;
    guess = g;
    guesslen = n;
    e.due = cyc + 66;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int budget = 0;
    while (sbq.size() > 0 && budget < 200) begin
      tick();
      budget++;
    end
    if (sbq.size() > 0) check("drain_timeout", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] rg;
    logic [3:0]   rl;
    reset = 1'b1;
    guess = '0;
    guesslen = '0;
    repeat (3) tick();
    check("reset_zero", hash_now(), 128'd0);

    reset = 1'b0;
    drive(G_A, 4'd0, "a", E_A);
    due = sbq[0].due;
    tick();
    drive(G_ABCD, 4'd2, "abc_masked", E_ABC);
    tick();
    drive(G_ABCD, 4'd3, "abcd", E_ABCD);
    while (cyc < due - 1) begin
      tick();
      guess = '0;
      guesslen = '0;
      check("fill_zero", hash_now(), 128'd0);
    end
    drain();

    drive(G_16, 4'd15, "len16", md5_ref(G_16, 16));
    for (int i = 0; i < 8; i++) begin
      tick();
      rg = {$urandom, $urandom, $urandom, $urandom};
      rl = 4'($urandom_range(0, 15));
      drive(rg, rl, $sformatf("rand%0d", i), md5_ref(rg, int'(rl) + 1));
    end
    drain();

    guess = G_16;
    guesslen = 4'd15;
    repeat (30) begin
      tick();
      guess = {$urandom, $urandom, $urandom, $urandom};
    end
    reset = 1'b1;
    tick();
    check("midreset_zero", hash_now(), 128'd0);
    reset = 1'b0;
    drive(G_ABCD, 4'd3, "post_reset", E_ABCD);
    due = sbq[0].due;
    while (cyc < due - 1) begin
      tick();
      check("post_reset_zero", hash_now(), 128'd0);
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
